// File: rtl/bcd_calc_core.sv
// bcd_calc_core: iterative packed-BCD add/sub/mul/div engine for the calculator
// display path. Operands are converted to binary with Horner steps (most
// significant digit first), evaluated, then converted back with double-dabble.
// Optional macro CALC_MOD_EN adds op 100 (remainder of the restoring divide).
//
//  state | meaning
//  IDLE  | waiting for start, outputs hold last result
//  CONV  | BCD-to-binary, one digit of each operand per cycle
//  EXEC  | arithmetic; one cycle, or one quotient bit per cycle for div/mod
//  B2D   | double-dabble, one bit per cycle
//  LOAD  | register result, sign, error and blank mask
//  DONE  | done pulse, back to IDLE next cycle
module bcd_calc_core #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   result_bcd,
  output logic                  neg,
  output logic                  err,
  output logic [2*DIGITS-1:0]   blank
);
  localparam int OW = 4 * DIGITS;
  localparam int RD = 2 * DIGITS;
  localparam int RW = 8 * DIGITS;
  localparam int CW = 6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  typedef enum logic [2:0] {IDLE, CONV, EXEC, B2D, LOAD, DONE} state_t;

  state_t          state, state_nx;
  logic [2:0]      op_r;
  logic [OW-1:0]   a_r, b_r, acc_a, acc_b, rem, rem_nx, quo_nx;
  logic [OW:0]     rem_sh;
  logic            ge;
  logic [RW-1:0]   res, bcd, arith_res;
  logic            arith_neg;
  logic [CW-1:0]   cnt;
  logic            tc, bad, err_i, neg_i, div_like, illegal, fault;
  logic [3:0]      dig_a, dig_b;
  logic [RD-1:0]   blank_nx;
  logic [2*RW-1:0] dd_nx;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  function automatic logic [2*RW-1:0] dd_step(input logic [RW-1:0] d, input logic [RW-1:0] b);
    logic [RW-1:0] adj;
    adj = d;
    for (int i = 0; i < RD; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj, b} << 1;
  endfunction

  assign tc = (cnt == CW'(1));

`ifdef CALC_MOD_EN
  assign div_like = (op_r == OP_DIV) || (op_r == 3'd4);
  assign illegal  = (op_r > 3'd4);
`else
  assign div_like = (op_r == OP_DIV);
  assign illegal  = (op_r > OP_DIV);
`endif
  assign fault = bad || illegal || (div_like && (acc_b == '0));

  // Pick the digit addressed by the conversion counter (MS digit first).
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < DIGITS; i++)
      if (cnt == CW'(i + 1)) begin
        dig_a = a_r[4*i +: 4];
        dig_b = b_r[4*i +: 4];
      end
  end

  // Restoring divide step: acc_a doubles as the quotient shift register.
  always_comb begin
    rem_sh = {rem, acc_a[OW-1]};
    ge     = (rem_sh >= {1'b0, acc_b});
    rem_nx = ge ? OW'(rem_sh - {1'b0, acc_b}) : rem_sh[OW-1:0];
    quo_nx = {acc_a[OW-2:0], ge};
  end

  // Single-cycle arithmetic result and the final divide-step result.
  always_comb begin
    arith_res = '0;
    arith_neg = 1'b0;
    case (op_r)
      OP_ADD: arith_res = RW'(acc_a) + RW'(acc_b);
      OP_SUB: begin
        arith_neg = (acc_b > acc_a);
        arith_res = arith_neg ? RW'(acc_b - acc_a) : RW'(acc_a - acc_b);
      end
      OP_MUL: arith_res = RW'(acc_a) * RW'(acc_b);
`ifdef CALC_MOD_EN
      3'd4:   arith_res = RW'(rem_nx);
`endif
      default: arith_res = RW'(quo_nx);
    endcase
  end

  // Leading-zero mask from the converted digits; digit 0 always shown.
  always_comb begin
    blank_nx = '0;
    blank_nx[RD-1] = (bcd[4*(RD-1) +: 4] == 4'd0);
    for (int k = RD - 2; k >= 1; k--)
      blank_nx[k] = blank_nx[k+1] && (bcd[4*k +: 4] == 4'd0);
  end

  assign dd_nx = dd_step(bcd, res);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = CONV;
      CONV: if (tc) state_nx = EXEC;
      EXEC: begin
        if (fault)                state_nx = LOAD;
        else if (!div_like || tc) state_nx = B2D;
      end
      B2D:  if (tc) state_nx = LOAD;
      LOAD: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CONV, EXEC, B2D, LOAD: busy = 1'b1;
      DONE:                  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, conversion, arithmetic, double-dabble, result register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r <= '0; a_r <= '0; b_r <= '0; acc_a <= '0; acc_b <= '0; rem <= '0;
      res <= '0; bcd <= '0; cnt <= '0; bad <= 1'b0; err_i <= 1'b0; neg_i <= 1'b0;
      result_bcd <= '0; neg <= 1'b0; err <= 1'b0;
      blank <= {{(RD-1){1'b1}}, 1'b0};
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r <= op; a_r <= a_bcd; b_r <= b_bcd;
          acc_a <= '0; acc_b <= '0; rem <= '0; bcd <= '0;
          bad <= 1'b0; err_i <= 1'b0; neg_i <= 1'b0;
          cnt <= CW'(DIGITS);
        end
        CONV: begin
          acc_a <= acc_a * OW'(10) + OW'(dig_a);
          acc_b <= acc_b * OW'(10) + OW'(dig_b);
          bad   <= bad || (dig_a > 4'd9) || (dig_b > 4'd9);
          cnt   <= tc ? CW'(OW) : cnt - 1'b1;
        end
        EXEC: begin
          if (fault) begin
            err_i <= 1'b1;
            neg_i <= 1'b0;
          end else if (div_like) begin
            acc_a <= quo_nx;
            rem   <= rem_nx;
            if (tc) begin
              res <= arith_res;
              cnt <= CW'(RW);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else begin
            res   <= arith_res;
            neg_i <= arith_neg;
            cnt   <= CW'(RW);
          end
        end
        B2D: begin
          bcd <= dd_nx[2*RW-1:RW];
          res <= dd_nx[RW-1:0];
          cnt <= cnt - 1'b1;
        end
        LOAD: begin
          result_bcd <= bcd;
          neg        <= neg_i;
          err        <= err_i;
          blank      <= blank_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_calc_core.sv
// Bench for bcd_calc_core (DIGITS=2): directed vectors with literal expectations,
// an arithmetic model in plain integers, and one per-cycle compare process.
module tb_bcd_calc_core;
  localparam int D  = 2;
  localparam int RD = 2 * D;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] op = '0;
  logic [4*D-1:0] a_bcd = '0, b_bcd = '0;
  logic busy, done, neg, err;
  logic [4*RD-1:0] result_bcd;
  logic [RD-1:0] blank;

  int checks = 0;
  int errors = 0;
  bit active = 1'b0;
  bit holding = 1'b0;
  int cyc = 0;

  logic [4*RD-1:0] m_res = '0, h_res = '0;
  logic m_neg = 1'b0, h_neg = 1'b0, m_err = 1'b0, h_err = 1'b0;
  logic [RD-1:0] m_blank = '0, h_blank = '0;
  int m_lat = 0;

  typedef struct {
    logic [2:0] op; logic [7:0] a; logic [7:0] b;
    logic [15:0] res; logic n; logic e; logic [3:0] bl; int lat;
  } vec_t;

  vec_t vecs [15] = '{
    '{3'd0, 8'h47, 8'h85, 16'h0132, 1'b0, 1'b0, 4'b1000, 20},
    '{3'd1, 8'h47, 8'h85, 16'h0038, 1'b1, 1'b0, 4'b1100, 20},
    '{3'd1, 8'h33, 8'h33, 16'h0000, 1'b0, 1'b0, 4'b1110, 20},
    '{3'd2, 8'h99, 8'h99, 16'h9801, 1'b0, 1'b0, 4'b0000, 20},
    '{3'd3, 8'h85, 8'h04, 16'h0021, 1'b0, 1'b0, 4'b1100, 27},
    '{3'd3, 8'h85, 8'h00, 16'h0000, 1'b0, 1'b1, 4'b1110, 4},
    '{3'd0, 8'h4A, 8'h01, 16'h0000, 1'b0, 1'b1, 4'b1110, 4},
    '{3'd5, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 4'b1110, 4},
    '{3'd1, 8'h85, 8'h47, 16'h0038, 1'b0, 1'b0, 4'b1100, 20},
    '{3'd0, 8'h99, 8'h99, 16'h0198, 1'b0, 1'b0, 4'b1000, 20},
    '{3'd3, 8'h99, 8'h07, 16'h0014, 1'b0, 1'b0, 4'b1100, 27},
    '{3'd2, 8'h00, 8'h57, 16'h0000, 1'b0, 1'b0, 4'b1110, 20},
    '{3'd3, 8'h07, 8'h09, 16'h0000, 1'b0, 1'b0, 4'b1110, 27},
    '{3'd7, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 4'b1110, 4},
    '{3'd2, 8'h12, 8'h3B, 16'h0000, 1'b0, 1'b1, 4'b1110, 4}
  };

  bcd_calc_core #(.DIGITS(D)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .busy(busy), .done(done),
    .result_bcd(result_bcd), .neg(neg), .err(err), .blank(blank)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Calculator semantics in plain integers: decode, compute, re-encode.
  task automatic model(input logic [2:0] o, input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                       output logic [4*RD-1:0] res, output logic n, output logic e,
                       output logic [RD-1:0] bl, output int lat);
    int av, bv, r, p, da, db;
    bit bad, legal, dl;
    av = 0; bv = 0; r = 0; bad = 0;
    for (int i = D - 1; i >= 0; i--) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1;
      av = av * 10 + da;
      bv = bv * 10 + db;
    end
`ifdef CALC_MOD_EN
    legal = (o <= 3'd4);
    dl = (o == 3'd3) || (o == 3'd4);
`else
    legal = (o <= 3'd3);
    dl = (o == 3'd3);
`endif
    n = 1'b0;
    e = bad || !legal || (dl && bv == 0);
    if (!e) begin
      case (o)
        3'd0: r = av + bv;
        3'd1: begin r = (av >= bv) ? av - bv : bv - av; n = (bv > av); end
        3'd2: r = av * bv;
        3'd3: r = av / bv;
        default: r = av % bv;
      endcase
    end
    lat = e ? D + 2 : D + (dl ? 4 * D : 1) + 8 * D + 1;
    res = '0;
    p = r;
    for (int i = 0; i < RD; i++) begin
      res[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    bl = '0;
    p = 10;
    for (int k = 1; k < RD; k++) begin
      bl[k] = (r < p);
      p = p * 10;
    end
  endtask

  // Compare process: busy/done timing while an operation is in flight,
  // result registers at done and while holding afterwards.
  initial begin
    forever begin
      @(negedge clock);
      if (active) begin
        cyc++;
        chk("busy", 32'(busy), 32'(cyc < m_lat));
        chk("done", 32'(done), 32'(cyc == m_lat));
        if (cyc >= m_lat) begin
          chk("result_bcd", 32'(result_bcd), 32'(m_res));
          chk("neg", 32'(neg), 32'(m_neg));
          chk("err", 32'(err), 32'(m_err));
          chk("blank", 32'(blank), 32'(m_blank));
          h_res = m_res; h_neg = m_neg; h_err = m_err; h_blank = m_blank;
          active = 1'b0;
          holding = 1'b1;
        end
      end else if (holding) begin
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_done", 32'(done), 32'(0));
        chk("hold_result", 32'(result_bcd), 32'(h_res));
        chk("hold_neg", 32'(neg), 32'(h_neg));
        chk("hold_err", 32'(err), 32'(h_err));
        chk("hold_blank", 32'(blank), 32'(h_blank));
      end
    end
  end

  task automatic launch(input vec_t v);
    model(v.op, v.a, v.b, m_res, m_neg, m_err, m_blank, m_lat);
    chk("pin_res", 32'(m_res), 32'(v.res));
    chk("pin_neg", 32'(m_neg), 32'(v.n));
    chk("pin_err", 32'(m_err), 32'(v.e));
    chk("pin_blank", 32'(m_blank), 32'(v.bl));
    chk("pin_lat", 32'(m_lat), 32'(v.lat));
    @(negedge clock);
    #1;
    op = v.op; a_bcd = v.a; b_bcd = v.b; start = 1'b1;
    cyc = -1;
    holding = 1'b0;
    active = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && active; i++) @(negedge clock);
    #1;
    if (active) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", m_lat);
      active = 1'b0;
    end
  endtask

  task automatic set_reset_hold();
    h_res = '0; h_neg = 1'b0; h_err = 1'b0; h_blank = {{(RD-1){1'b1}}, 1'b0};
    active = 1'b0;
    holding = 1'b1;
  endtask

  vec_t v;

  initial begin
    #1;
    reset = 1'b0;
    set_reset_hold();
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result_bcd), 32'(0));
    chk("rst_blank", 32'(blank), 32'(4'b1110));
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 15; i++) begin
      launch(vecs[i]);
      wait_done();
      repeat (2) @(negedge clock);
    end

`ifdef CALC_MOD_EN
    v = '{3'd4, 8'h85, 8'h04, 16'h0001, 1'b0, 1'b0, 4'b1110, 27};
`else
    v = '{3'd4, 8'h85, 8'h04, 16'h0000, 1'b0, 1'b1, 4'b1110, 4};
`endif
    launch(v);
    wait_done();

    // start re-asserted mid-operation with other operands must be ignored
    launch(vecs[0]);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1; op = 3'd2; a_bcd = 8'h11; b_bcd = 8'h22;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clock);

    // reset in the middle of an operation: abort, no done, clean restart
    launch(vecs[3]);
    repeat (9) @(posedge clock);
    #1;
    set_reset_hold();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    launch(vecs[4]);
    wait_done();
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_calc_core.md
Name: bcd_calc_core

Overview:
Parametrised sequential BCD arithmetic core for the board-level calculator. It takes two DIGITS-wide packed-BCD operands and an opcode under a start/busy/done handshake. It returns a 2*DIGITS-digit BCD magnitude with sign, error and leading-zero blank flags, ready for the 7-segment digit mux. Operation is iterative: Horner BCD-to-binary, single-cycle add/sub/mul or restoring divide, then double-dabble binary-to-BCD.

Parameters:
DIGITS, 2, operand digit count (1..4); derived localparams OW=4*DIGITS (operand binary width), RD=2*DIGITS (result digits), RW=8*DIGITS (result binary width)

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 mod (CALC_MOD_EN only), others illegal
a_bcd  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
b_bcd  input  4*DIGITS  operand B, same format
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result outputs valid from this cycle on
result_bcd  output  4*RD  result magnitude, packed BCD
neg  output  1  result is negative (sub only)
err  output  1  divide-by-zero, illegal op or non-BCD operand digit
blank  output  RD  bit k=1: digit k is a leading zero; bit 0 is always 0

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, neg, err = 0; result_bcd = 0; blank = all ones except bit 0. Mid-operation reset aborts with no done pulse.
- IDLE: on posedge with start=1, latch op, a_bcd, b_bcd; clear done. Go to CONV with busy=1. start outside IDLE is ignored; latched inputs do not change.
- CONV (DIGITS cycles): MS digit first, accA=accA*10+digit, accB likewise. Any digit >9 sets an internal bad flag.
- EXEC, first cycle: bad flag, illegal op, or (div/mod with B=0) -> err=1, result 0, neg=0; go to DONE next cycle. Latency start-edge to done = DIGITS+2.
- EXEC, add: R=A+B. Sub: R=|A-B|, neg=1 iff B>A (A==B gives neg=0). Mul: R=A*B. Each takes 1 cycle.
- EXEC, div/mod: restoring shift-subtract, one quotient bit per cycle, OW cycles total. Quotient (div) or remainder (mod) goes to R.
- B2D (RW cycles): double-dabble of RW-bit R; add 3 to any nibble >=5 before each shift.
- DONE (1 cycle): done=1, busy=0, result_bcd/neg/err/blank registered. Next cycle go to IDLE; done=0; outputs hold until the next accepted start.
- Latency start-edge to done, valid ops: DIGITS + E + RW + 1; E=1 (add/sub/mul), E=OW (div/mod).
- Widths: RW bits hold (10^DIGITS-1)^2, so no overflow is possible. Sum <= 2*(10^DIGITS-1) fits RD digits.
- blank: bit k set iff all digits k..RD-1 are zero, k>=1. A zero result shows a single "0".
- start arriving in the DONE cycle is not accepted; it must be held or re-asserted in IDLE.

Optional Feature:
CALC_MOD_EN. Defined: op 100 runs the restoring divide and returns the remainder, with divide latency and B=0 -> err. Undefined: op 100 is illegal (err=1, latency DIGITS+2) and the remainder path is not built.

Test Plan:
- DIGITS=2, add a=0x47 b=0x85 -> done after 20 cycles, result_bcd=0x0132, neg=0, err=0, blank=4'b1000.
- sub a=0x47 b=0x85 -> result_bcd=0x0038, neg=1, blank=4'b1100; sub a=0x33 b=0x33 -> 0x0000, neg=0, blank=4'b1110.
- mul a=0x99 b=0x99 -> result_bcd=0x9801, blank=0, latency 20; div a=0x85 b=0x04 -> 0x0021, latency 27.
- div a=0x85 b=0x00 -> err=1, result_bcd=0, done 4 cycles after start. a=0x4A add -> err=1. op=101 -> err=1.
- With CALC_MOD_EN: op=100 a=0x85 b=0x04 -> result 0x0001. Without it: same stimulus -> err=1, latency 4.
- Assert start again at busy cycle 5 with different operands -> ignored, first result unchanged. Pull reset low at cycle 10 -> immediate IDLE, busy=0, no done; next start works normally.
